// File: rtl/fft_sdf_pkg.sv
// fft_sdf_pkg: shared types, default geometry and the delay clamp for the SDF stage buffer
package fft_sdf_pkg;
  localparam int DEF_DATA_WIDTH = 9;
  localparam int DEF_LANES = 16;
  localparam int DEF_DEPTH = 16;
  typedef enum logic [1:0] {IDLE, FILL, BFLY} state_t;
  typedef logic signed [DEF_DATA_WIDTH-1:0] lane_t;
  typedef lane_t [DEF_LANES-1:0] lane_vec_t;
  function automatic int clamp_delay(input int cfg, input int depth);
    return cfg < 1 ? 1 : cfg > depth ? depth : cfg;
  endfunction
endpackage

// File: rtl/fft_sdf_delay_buf_circ_mem.sv
// fft_sdf_circ_mem: DEPTH-entry circular vector store, one sync write port, one async read port
//   clk          rising-edge write clock
//   we/waddr/wdata  write port
//   raddr/rdata     combinational read port
module fft_sdf_circ_mem
  import fft_sdf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W = 2 * DEF_LANES * DEF_DATA_WIDTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fft_sdf_delay_buf.sv
// fft_sdf_delay_buf: radix-2 SDF stage delay buffer pairing first-half vectors with second-half vectors
//   clk, rstn            clock, asynchronous active-low reset
//   din_valid            input beat valid (no backpressure)
//   frame_start          marks an accepted beat as beat 0 of a block
//   flush                synchronous abort to IDLE, wins over din_valid
//   cfg_delay            requested delay D, clamped to 1..DEPTH, latched at beat 0
//   din_i/din_q          input lane vectors
//   dout_a_i/dout_a_q    stored first-half vector of a butterfly pair
//   dout_b_i/dout_b_q    matching second-half vector
//   bufly_enable         one cycle per presented pair
//   busy                 high while in FILL or BFLY
//   sync_err             only with FFT_SDF_BUF_ERR_EN: sticky mid-block frame_start flag
module fft_sdf_delay_buf
  import fft_sdf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = DEF_DEPTH,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               din_valid,
  input  logic                               frame_start,
  input  logic                               flush,
  input  logic [DW-1:0]                      cfg_delay,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]   din_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]   din_q,
  output logic [LANES-1:0][DATA_WIDTH-1:0]   dout_a_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0]   dout_a_q,
  output logic [LANES-1:0][DATA_WIDTH-1:0]   dout_b_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0]   dout_b_q,
  output logic                               bufly_enable,
`ifdef FFT_SDF_BUF_ERR_EN
  output logic                               sync_err,
`endif
  output logic                               busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int VW = 2 * LANES * DATA_WIDTH;
  state_t state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d, d_q, d_d, d_new, d_eff, beat_idx;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr, mem_waddr;
  logic [DW:0] rd_sum;
  logic [VW-1:0] rd_data;
  logic acc, active, beat0, in_bfly, last, we, fire;
  always_comb begin
    acc = din_valid & ~flush;
    active = state_q != IDLE || frame_start;
    // beat 0 is either an explicit frame_start or the first beat after a completed block
    beat0 = frame_start || (state_q == FILL && cnt_q == '0);
    d_new = DW'(clamp_delay(int'(cfg_delay), DEPTH));
    d_eff = beat0 ? d_new : d_q;
    beat_idx = beat0 ? '0 : cnt_q;
    last = beat_idx == d_eff - 1'b1;
    in_bfly = state_q == BFLY && !frame_start;
    we = acc && active;
    fire = acc && in_bfly;
    // partner slot is D beats behind the write pointer, modulo DEPTH
    rd_sum = (DW+1)'(wr_ptr_q) + (DW+1)'(DEPTH) - {1'b0, d_q};
    rd_ptr = PW'(rd_sum >= (DW+1)'(DEPTH) ? rd_sum - (DW+1)'(DEPTH) : rd_sum);
    mem_waddr = in_bfly ? rd_ptr : wr_ptr_q;
    wr_ptr_d = !we ? wr_ptr_q : wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
    state_d = flush ? IDLE : !we ? state_q : in_bfly ? (last ? FILL : BFLY) : (last ? BFLY : FILL);
    cnt_d = flush ? '0 : !we ? cnt_q : last ? '0 : beat_idx + 1'b1;
    d_d = we && beat0 ? d_new : d_q;
  end
  fft_sdf_circ_mem #(.DEPTH(DEPTH), .W(VW)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(mem_waddr),
    .wdata({din_q, din_i}),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      d_q <= '0;
      wr_ptr_q <= '0;
      bufly_enable <= 1'b0;
      busy <= 1'b0;
      dout_a_i <= '0;
      dout_a_q <= '0;
      dout_b_i <= '0;
      dout_b_q <= '0;
`ifdef FFT_SDF_BUF_ERR_EN
      sync_err <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      d_q <= d_d;
      wr_ptr_q <= wr_ptr_d;
      bufly_enable <= fire;
      busy <= state_d != IDLE;
      if (fire) begin
        dout_a_i <= rd_data[VW/2-1:0];
        dout_a_q <= rd_data[VW-1:VW/2];
        dout_b_i <= din_i;
        dout_b_q <= din_q;
      end
`ifdef FFT_SDF_BUF_ERR_EN
      sync_err <= flush ? 1'b0 : sync_err | (acc && frame_start && cnt_q != '0);
`endif
    end
endmodule

// File: tb/tb_fft_sdf_delay_buf.sv
// tb_fft_sdf_delay_buf: randomized scoreboard bench for the SDF delay buffer
module tb_fft_sdf_delay_buf;
  import fft_sdf_pkg::*;
  localparam int DWD = $clog2(DEF_DEPTH + 1);
  localparam int VB = DEF_LANES * DEF_DATA_WIDTH;
  typedef struct { lane_vec_t ai, aq, bi, bq; } pair_t;
  logic clk = 0, rstn = 0, din_valid = 0, frame_start = 0, flush = 0;
  logic [DWD-1:0] cfg_delay = '0;
  lane_vec_t din_i = '0, din_q = '0, dout_a_i, dout_a_q, dout_b_i, dout_b_q;
  logic bufly_enable, busy;
`ifdef FFT_SDF_BUF_ERR_EN
  logic sync_err;
`endif
  int vectors = 0, miscompares = 0;
  pair_t sb[$];
  pair_t last_p = '{default: '0};
  lane_vec_t blk_i[$], blk_q[$];
  bit started = 0, nxt_busy = 0, exp_busy = 0, nxt_err = 0, exp_err = 0;
  int md = 1;

  fft_sdf_delay_buf dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .frame_start(frame_start),
    .flush(flush), .cfg_delay(cfg_delay), .din_i(din_i), .din_q(din_q),
    .dout_a_i(dout_a_i), .dout_a_q(dout_a_q), .dout_b_i(dout_b_i), .dout_b_q(dout_b_q),
    .bufly_enable(bufly_enable),
`ifdef FFT_SDF_BUF_ERR_EN
    .sync_err(sync_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic void chk(input string n, input logic [VB-1:0] act, input logic [VB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endfunction

  initial forever begin
    @(negedge clk);
    if (bufly_enable === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL extra_pulse: bufly_enable got 1 required 0");
      end else last_p = sb.pop_front();
    end
    chk("dout_a_i", dout_a_i, last_p.ai);
    chk("dout_a_q", dout_a_q, last_p.aq);
    chk("dout_b_i", dout_b_i, last_p.bi);
    chk("dout_b_q", dout_b_q, last_p.bq);
    chk("busy", VB'(busy), VB'(exp_busy));
`ifdef FFT_SDF_BUF_ERR_EN
    chk("sync_err", VB'(sync_err), VB'(exp_err));
`endif
  end

  task automatic beat(input bit v, input bit fs, input int cfg, input bit fl, input int lane0);
    lane_vec_t vi, vq;
    @(posedge clk);
    #1;
    exp_busy = nxt_busy;
    exp_err = nxt_err;
    for (int l = 0; l < DEF_LANES; l++) begin
      vi[l] = lane_t'($urandom);
      vq[l] = lane_t'($urandom);
    end
    if (lane0 >= 0) vi[0] = lane_t'(lane0);
    din_valid = v;
    frame_start = fs;
    cfg_delay = DWD'(cfg);
    flush = fl;
    din_i = vi;
    din_q = vq;
    if (fl) begin
      started = 0;
      nxt_busy = 0;
      nxt_err = 0;
    end else if (v) begin
      if (fs || (started && blk_i.size() == 2 * md)) begin
        if (fs && started && blk_i.size() != md && blk_i.size() != 2 * md) nxt_err = 1;
        started = 1;
        md = cfg < 1 ? 1 : cfg > DEF_DEPTH ? DEF_DEPTH : cfg;
        blk_i.delete();
        blk_q.delete();
      end
      if (started) begin
        blk_i.push_back(vi);
        blk_q.push_back(vq);
        if (blk_i.size() > md)
          sb.push_back('{blk_i[blk_i.size()-1-md], blk_q[blk_q.size()-1-md], vi, vq});
      end
      nxt_busy = started;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(0, 0, 0, 0, -1);
  endtask

  task automatic drain(input string n);
    idle(3);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d pairs never presented, required 0", n, sb.size());
    end
    sb.delete();
  endtask

  task automatic rst_chk(input string n);
    chk({n, "_bufly"}, VB'(bufly_enable), '0);
    chk({n, "_busy"}, VB'(busy), '0);
    chk({n, "_dout_a_i"}, dout_a_i, '0);
    chk({n, "_dout_a_q"}, dout_a_q, '0);
    chk({n, "_dout_b_i"}, dout_b_i, '0);
    chk({n, "_dout_b_q"}, dout_b_q, '0);
`ifdef FFT_SDF_BUF_ERR_EN
    chk({n, "_sync_err"}, VB'(sync_err), '0);
`endif
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rstn = 0;
    din_valid = 0;
    frame_start = 0;
    flush = 0;
    sb.delete();
    last_p = '{default: '0};
    started = 0;
    nxt_busy = 0;
    exp_busy = 0;
    nxt_err = 0;
    exp_err = 0;
    #1;
    rst_chk("async_rst");
    repeat (2) @(negedge clk);
    #2 rstn = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_chk("por");
    #2 rstn = 1;
    for (int k = 0; k < 32; k++) beat(1, k == 0, 16, 0, k);
    drain("d16_block");
    for (int k = 0; k < 8; k++) begin
      beat(1, k == 0, 4, 0, k);
      beat(0, 0, 4, 0, -1);
    end
    drain("d4_bubbles");
    for (int k = 0; k < 2; k++) beat(1, k == 0, 0, 0, k);
    drain("cfg0_clamp");
    for (int k = 0; k < 32; k++) beat(1, k == 0, 20, 0, k);
    drain("cfg20_clamp");
    for (int k = 0; k < 4; k++) beat(1, k == 0, 2, 0, k);
    for (int k = 0; k < 16; k++) beat(1, 0, 8, 0, 4 + k);
    drain("back_to_back");
    for (int k = 0; k < 5; k++) beat(1, k == 0, 8, 0, k);
    beat(1, 0, 8, 1, 5);
    for (int k = 0; k < 4; k++) beat(1, 0, 8, 0, 6 + k);
    for (int k = 0; k < 16; k++) beat(1, k == 0, 8, 0, 50 + k);
    drain("flush_then_clean");
    for (int k = 0; k < 3; k++) beat(1, k == 0, 8, 0, k);
    for (int k = 0; k < 16; k++) beat(1, k == 0, 8, 0, 100 + k);
    drain("mid_block_resync");
    beat(0, 0, 0, 1, -1);
    idle(1);
    for (int k = 0; k < 6; k++) beat(1, k == 0, 4, 0, k);
    async_reset();
    idle(2);
    repeat (600)
      beat($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, int'($urandom_range(0, 31)),
           $urandom_range(0, 49) == 0, -1);
    drain("random");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
